// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART handshake bundle for the UART transmit arbiter.
// master: requesters plus UART transmitter side; slave: the arbiter.
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  uart_din;
    logic        uart_write_en;
    logic        uart_tx_busy;
    logic [3:0]  grant;
    logic        lock;
    logic        timeout_err;

    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, uart_din, uart_write_en, grant, lock, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, uart_din, uart_write_en, grant, lock, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding one UART transmitter.
// A byte without req_last locks the UART to its sender until the message ends;
// a write request that the UART never acknowledges is dropped after TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd20000
) (
    input  logic             clk50,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e      state_q;
    logic [1:0]  ptr_q;
    logic [1:0]  owner_q;
    logic        lock_q;
    logic [15:0] cnt_q;
    logic [7:0]  din_q;
    logic [3:0]  grant_q;
    logic        we_q;
    logic        terr_q;

    logic [1:0]  sel;
    logic        sel_vld;
    logic [3:0]  ready;
    logic        accept;

    // Pick the eligible requester: the lock owner only, else the first valid one from ptr_q up.
    always_comb begin
        sel     = ptr_q;
        sel_vld = 1'b0;
        if (lock_q) begin
            sel     = owner_q;
            sel_vld = bus.req_valid[owner_q];
        end else begin
            // Descending scan so the smallest offset from ptr_q wins.
            for (int k = 3; k >= 0; k--) begin
                if (bus.req_valid[ptr_q + 2'(k)]) begin
                    sel     = ptr_q + 2'(k);
                    sel_vld = 1'b1;
                end
            end
        end
    end

    // Ready is combinational; gated by rst_n so nothing is offered while in reset.
    always_comb begin
        ready = '0;
        if (rst_n && (state_q == StIdle) && !bus.uart_tx_busy && sel_vld) begin
            ready[sel] = 1'b1;
        end
    end

    assign accept = |ready;

    // Arbitration FSM with registered UART-side outputs.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            lock_q  <= 1'b0;
            cnt_q   <= 16'd0;
            din_q   <= 8'd0;
            grant_q <= 4'd0;
            we_q    <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        din_q   <= bus.req_data[{sel, 3'b000} +: 8];
                        grant_q <= 4'b0001 << sel;
                        owner_q <= sel;
                        cnt_q   <= 16'd0;
                        we_q    <= 1'b1;
                        state_q <= StIssue;
                        if (bus.req_last[sel]) begin
                            lock_q <= 1'b0;
                            ptr_q  <= sel + 2'd1;
                        end else begin
                            lock_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (bus.uart_tx_busy) begin
                        we_q    <= 1'b0;
                        state_q <= StWaitDone;
                    end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                        // UART never took the byte: drop it and release the lock.
                        we_q    <= 1'b0;
                        terr_q  <= 1'b1;
                        lock_q  <= 1'b0;
                        ptr_q   <= owner_q + 2'd1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StWaitDone: begin
                    if (!bus.uart_tx_busy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready     = ready;
    assign bus.uart_din      = din_q;
    assign bus.uart_write_en = we_q;
    assign bus.grant         = grant_q;
    assign bus.lock          = lock_q;
    assign bus.timeout_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table for arbitration order, scoreboard of
// transmitted bytes, and hand sequences for lock, timeout, stray busy and reset.
module tb_uart_tx_arbiter;

    logic clk50;
    logic rst_n;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.TIMEOUT_CYC(16'd8)) dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;
    logic        model_busy;
    logic        force_busy;
    int          busy_len;
    int          busy_cnt;

    assign bus.req_valid    = vld;
    assign bus.req_last     = lst;
    assign bus.req_data     = dat;
    assign bus.uart_tx_busy = model_busy | force_busy;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_byte;
    } vec_t;

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    // UART model: busy rises one cycle after write_en and stays high busy_len cycles.
    always @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) model_busy <= 1'b0;
        end else if (bus.uart_write_en && busy_len > 0 && !model_busy) begin
            model_busy <= 1'b1;
            busy_cnt   <= busy_len;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pops one expectation per rising edge of uart_write_en.
    task automatic monitor();
        logic we_prev;
        exp_t e;
        we_prev = 1'b0;
        forever begin
            @(negedge clk50);
            if (bus.uart_write_en && !we_prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: write of %h grant %b with empty queue",
                             bus.uart_din, bus.grant);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_din", 32'(bus.uart_din), 32'(e.b));
                    chk("sb_grant", 32'(bus.grant), 32'(e.g));
                end
            end
            we_prev = bus.uart_write_en;
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in idle.
    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk50);
            if (!bus.uart_write_en && !bus.uart_tx_busy) done = 1'b1;
        end
        chk("idle_wait", 32'(done), 32'd1);
        @(negedge clk50);
    endtask

    // Called at a negedge; waits for req_ready[i], lets the accept edge pass, drops valid.
    task automatic wait_accept(input int i);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            #1;
            if (bus.req_ready[i]) got = 1'b1;
            else @(negedge clk50);
        end
        chk("accept_wait", 32'(got), 32'd1);
        @(posedge clk50);
        @(negedge clk50);
        vld[i] = 1'b0;
    endtask

    task automatic send_byte(input int i, input logic [7:0] b, input logic last);
        vld[i]         = 1'b1;
        lst[i]         = last;
        dat[8*i +: 8]  = b;
        wait_accept(i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(bus.uart_write_en), 32'd0);
        chk({tag, "_din"},   32'(bus.uart_din),      32'd0);
        chk({tag, "_grant"}, 32'(bus.grant),         32'd0);
        chk({tag, "_lock"},  32'(bus.lock),          32'd0);
        chk({tag, "_terr"},  32'(bus.timeout_err),   32'd0);
        chk({tag, "_ready"}, 32'(bus.req_ready),     32'd0);
    endtask

    initial begin
        vec_t tbl[10];
        int   we_cnt;
        int   te_cnt;
        bit   ok;

        tbl[0] = '{4'hF, 4'hF, 32'h44332211, 4'b0001, 8'h11};
        tbl[1] = '{4'hF, 4'hF, 32'h44332211, 4'b0010, 8'h22};
        tbl[2] = '{4'hF, 4'hF, 32'h44332211, 4'b0100, 8'h33};
        tbl[3] = '{4'hF, 4'hF, 32'h44332211, 4'b1000, 8'h44};
        tbl[4] = '{4'hF, 4'hF, 32'h44332211, 4'b0001, 8'h11};
        tbl[5] = '{4'h1, 4'hF, 32'hA0B0C0D0, 4'b0001, 8'hD0};
        tbl[6] = '{4'hC, 4'hF, 32'h55667788, 4'b0100, 8'h66};
        tbl[7] = '{4'h3, 4'hF, 32'h01020304, 4'b0001, 8'h04};
        tbl[8] = '{4'hA, 4'hA, 32'hDEADBEEF, 4'b0010, 8'hBE};
        tbl[9] = '{4'h8, 4'h8, 32'h9A000000, 4'b1000, 8'h9A};

        n_vec      = 0;
        n_err      = 0;
        vld        = 4'h0;
        lst        = 4'h0;
        dat        = 32'h0;
        force_busy = 1'b0;
        busy_len   = 10;
        rst_n      = 1'b0;

        fork
            monitor();
        join_none

        // Reset state, including ready held low with requests present.
        #2;
        vld = 4'hF;
        #1;
        chk_all_zero("reset");
        vld = 4'h0;
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;

        // Table: round-robin order, wrap-around and byte lane selection.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk50);
            vld = tbl[v].valid;
            lst = tbl[v].last;
            dat = tbl[v].data;
            #1;
            chk("vec_ready", 32'(bus.req_ready), 32'(tbl[v].exp_ready));
            exp_q.push_back('{g: tbl[v].exp_ready, b: tbl[v].exp_byte});
            @(posedge clk50);
            @(negedge clk50);
            vld = 4'h0;
            wait_idle();
        end

        // Locked message from requester 1 while requester 2 keeps asking.
        lst = 4'h0;
        vld[2] = 1'b1;
        lst[2] = 1'b1;
        dat[23:16] = 8'h77;
        exp_q.push_back('{g: 4'b0010, b: 8'h41});
        send_byte(1, 8'h41, 1'b0);
        chk("lock_set", 32'(bus.lock), 32'd1);
        wait_idle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk50);
            #1;
            chk("lock_gap_ready", 32'(bus.req_ready), 32'd0);
        end
        exp_q.push_back('{g: 4'b0010, b: 8'h42});
        send_byte(1, 8'h42, 1'b0);
        chk("lock_hold", 32'(bus.lock), 32'd1);
        wait_idle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk50);
            #1;
            chk("lock_gap_ready", 32'(bus.req_ready), 32'd0);
        end
        exp_q.push_back('{g: 4'b0010, b: 8'h43});
        exp_q.push_back('{g: 4'b0100, b: 8'h77});
        send_byte(1, 8'h43, 1'b1);
        chk("lock_clear", 32'(bus.lock), 32'd0);
        wait_accept(2);
        wait_idle();

        // Move the pointer back to 0 so the timeout's pointer update is observable.
        exp_q.push_back('{g: 4'b1000, b: 8'h3C});
        send_byte(3, 8'h3C, 1'b1);
        wait_idle();

        // Timeout: UART never goes busy.
        busy_len = 0;
        exp_q.push_back('{g: 4'b0100, b: 8'h5A});
        send_byte(2, 8'h5A, 1'b0);
        chk("to_lock_before", 32'(bus.lock), 32'd1);
        we_cnt = 0;
        te_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.uart_write_en) we_cnt++;
            if (bus.timeout_err) te_cnt++;
            @(negedge clk50);
        end
        chk("to_we_cycles", 32'(we_cnt), 32'd8);
        chk("to_err_pulses", 32'(te_cnt), 32'd1);
        chk("to_lock_after", 32'(bus.lock), 32'd0);
        busy_len = 10;
        vld = 4'hF;
        lst = 4'hF;
        dat = 32'h11223344;
        #1;
        chk("to_next_ready", 32'(bus.req_ready), 32'b1000);
        exp_q.push_back('{g: 4'b1000, b: 8'h11});
        @(posedge clk50);
        @(negedge clk50);
        vld = 4'h0;
        wait_idle();

        // Stray busy in idle blocks acceptance until it falls.
        force_busy = 1'b1;
        vld = 4'h1;
        lst = 4'h1;
        dat[7:0] = 8'h6B;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stray_busy_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk50);
        end
        force_busy = 1'b0;
        #1;
        chk("busy_fall_ready", 32'(bus.req_ready), 32'b0001);
        exp_q.push_back('{g: 4'b0001, b: 8'h6B});
        @(posedge clk50);
        @(negedge clk50);
        vld = 4'h0;
        wait_idle();

        // Asynchronous reset in WAIT_DONE with a lock held.
        exp_q.push_back('{g: 4'b0010, b: 8'hC3});
        send_byte(1, 8'hC3, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk50);
            if (bus.uart_tx_busy && !bus.uart_write_en) ok = 1'b1;
        end
        chk("reach_wait_done", 32'(ok), 32'd1);
        chk("wd_lock", 32'(bus.lock), 32'd1);
        @(posedge clk50);
        #3;
        rst_n = 1'b0;
        vld = 4'hF;
        lst = 4'hF;
        dat = 32'h4D3C2B1A;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk50);
        @(negedge clk50);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'b0001);
        exp_q.push_back('{g: 4'b0001, b: 8'h1A});
        @(posedge clk50);
        @(negedge clk50);
        vld = 4'h0;
        wait_idle();

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 20000, max clk50 cycles uart_write_en is held waiting for uart_tx_busy to rise (16-bit, >=1).
REQ-002 Port: clk50  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  4  per-requester byte valid, bit i = requester i.
REQ-005 Port: req_data  input  32  per-requester byte, requester i on [8i+7:8i].
REQ-006 Port: req_last  input  4  per-requester end-of-message flag, qualified by req_valid.
REQ-007 Port: req_ready  output  4  per-requester accept, at most one bit high.
REQ-008 Port: uart_din  output  8  byte to UART transmitter.
REQ-009 Port: uart_write_en  output  1  transmit request to UART transmitter.
REQ-010 Port: uart_tx_busy  input  1  UART transmitter busy.
REQ-011 Port: grant  output  4  one-hot current/last selected requester, 0 when none.
REQ-012 Port: lock  output  1  a multi-byte message owns the UART.
REQ-013 Port: timeout_err  output  1  one-cycle pulse on write handshake timeout.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT_DONE; encoding free.
REQ-015 In IDLE with lock=0, selected requester SHALL be first i with req_valid[i]=1 searching from priority pointer p upward, modulo 4.
REQ-016 In IDLE with lock=1, only the lock owner SHALL be eligible; other requesters SHALL wait even if owner's req_valid=0.
REQ-017 req_ready[i] SHALL be combinational: state==IDLE and uart_tx_busy==0 and i selected and req_valid[i]==1.
REQ-018 Byte accepted on rising edge with req_valid[i] and req_ready[i]: register req_data byte i into uart_din, grant=one-hot(i), go to ISSUE.
REQ-019 On accept with req_last[i]=0: lock=1, owner=i; with req_last[i]=1: lock=0, p=(i+1) mod 4.
REQ-020 uart_write_en SHALL be registered, high exactly while state==ISSUE; first high cycle is the cycle after accept (latency 1).
REQ-021 ISSUE -> WAIT_DONE on first cycle uart_tx_busy==1 is sampled; uart_write_en low from next cycle.
REQ-022 ISSUE timeout counter SHALL clear on entry and increment each ISSUE cycle; on reaching TIMEOUT_CYC without uart_tx_busy: go IDLE, pulse timeout_err 1 cycle, lock=0, p=(owner+1) mod 4, byte dropped.
REQ-023 WAIT_DONE -> IDLE on first cycle uart_tx_busy==0 sampled.
REQ-024 uart_din SHALL remain stable from accept until next accept.
REQ-025 IDLE with uart_tx_busy==1 (stray/external busy) SHALL accept nothing.
REQ-026 Simultaneous req_valid from several requesters with lock=0 SHALL grant exactly one per REQ-015; others see req_ready=0.
REQ-027 req_valid/req_data changes outside an accept edge SHALL have no effect on outputs.
REQ-028 Wrap-around: p=3, requester 3 finishes -> p=0.
REQ-029 Throughput: at most one byte per UART busy period; no new accept before uart_tx_busy falls.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, uart_write_en=0, uart_din=0, grant=0, lock=0, timeout_err=0, p=0, counter=0; req_ready=0 while rst_n low.
REQ-031 Reset during ISSUE or WAIT_DONE SHALL drop uart_write_en immediately; in-flight byte and lock discarded.
REQ-032 After rst_n rises, first accept possible on first clk50 edge with a valid request and uart_tx_busy=0.

Verification
REQ-033 All four req_valid high, req_last=4'hF, UART model busy 10 cycles per byte -> grants in order 0,1,2,3,0; uart_din = each requester's byte.
REQ-034 Requester 1 sends 0x41,0x42,0x43 (last on 0x43) with gaps of 5 cycles, requester 2 valid throughout -> 0x41,0x42,0x43 transmitted before any requester-2 byte; lock=1 until 0x43 accepted.
REQ-035 UART model never raises busy, TIMEOUT_CYC=8 -> uart_write_en high exactly 8 cycles, timeout_err pulses once, lock=0, next grant goes to owner+1.
REQ-036 uart_tx_busy forced high in IDLE with req_valid=4'h1 -> req_ready stays 0 until busy falls, then accept in that cycle.
REQ-037 rst_n pulsed low mid-WAIT_DONE with lock=1 -> all outputs 0 without clock edge; after release, requester 0 granted first.
